// File: rtl/commit_trace_buffer_if.sv
// Commit-trace port bundle: retire-lane inputs,
// trace record output and drop status.
interface commit_trace_buffer_if #(
  parameter int XLEN  = 32,
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int SEQ_W = 32
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [LANES-1:0]      cm_valid_i;
  logic [LANES*XLEN-1:0] cm_pc_i;
  logic [LANES*XLEN-1:0] cm_instr_i;
  logic [LANES*5-1:0]    cm_rd_addr_i;
  logic [LANES*XLEN-1:0] cm_rd_data_i;
  logic [LANES-1:0]      cm_mem_wrt_i;
  logic [LANES*XLEN-1:0] cm_mem_addr_i;
  logic [LANES*XLEN-1:0] cm_mem_data_i;
  logic                  cm_ready_o;

  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [SEQ_W-1:0]      out_seq_o;
  logic [XLEN-1:0]       out_pc_o;
  logic [XLEN-1:0]       out_instr_o;
  logic [4:0]            out_rd_addr_o;
  logic [XLEN-1:0]       out_rd_data_o;
  logic                  out_mem_wrt_o;
  logic [XLEN-1:0]       out_mem_addr_o;
  logic [XLEN-1:0]       out_mem_data_o;

  logic [LW-1:0]         level_o;
  logic                  overflow_o;
  logic [15:0]           drop_cnt_o;
  logic                  clear_i;

  modport master (
    output cm_valid_i, cm_pc_i, cm_instr_i,
    output cm_rd_addr_i, cm_rd_data_i,
    output cm_mem_wrt_i, cm_mem_addr_i,
    output cm_mem_data_i, out_ready_i, clear_i,
    input  cm_ready_o, out_valid_o, out_seq_o,
    input  out_pc_o, out_instr_o, out_rd_addr_o,
    input  out_rd_data_o, out_mem_wrt_o,
    input  out_mem_addr_o, out_mem_data_o,
    input  level_o, overflow_o, drop_cnt_o
  );

  modport slave (
    input  cm_valid_i, cm_pc_i, cm_instr_i,
    input  cm_rd_addr_i, cm_rd_data_i,
    input  cm_mem_wrt_i, cm_mem_addr_i,
    input  cm_mem_data_i, out_ready_i, clear_i,
    output cm_ready_o, out_valid_o, out_seq_o,
    output out_pc_o, out_instr_o, out_rd_addr_o,
    output out_rd_data_o, out_mem_wrt_o,
    output out_mem_addr_o, out_mem_data_o,
    output level_o, overflow_o, drop_cnt_o
  );
endinterface

// File: rtl/commit_trace_buffer.sv
// Multi-lane retire-trace FIFO: compacts valid
// lanes in order, tags seq, drains one per cycle.
module commit_trace_buffer #(
  parameter int XLEN  = 32,
  parameter int LANES = 2,
  parameter int DEPTH = 8,
  parameter int SEQ_W = 32
) (
  input  logic clk_i,
  input  logic rst_i,
  commit_trace_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]    wr_ptr, rd_ptr, level;
  logic [SEQ_W-1:0] next_seq;
  logic             overflow;
  logic [15:0]      drop_cnt;

  logic [XLEN-1:0]  pc_q   [DEPTH];
  logic [XLEN-1:0]  ins_q  [DEPTH];
  logic [4:0]       rda_q  [DEPTH];
  logic [XLEN-1:0]  rdd_q  [DEPTH];
  logic             mw_q   [DEPTH];
  logic [XLEN-1:0]  ma_q   [DEPTH];
  logic [XLEN-1:0]  md_q   [DEPTH];
  logic [SEQ_W-1:0] seq_q  [DEPTH];

  logic [AW-1:0] off   [LANES];
  logic [AW-1:0] waddr [LANES];
  logic [PW-1:0] cnt;
  logic [AW-1:0] raddr;
  logic          ready, any_v, push, drop;
  logic          valid, pop;

  assign ready = (level <= PW'(DEPTH - LANES));
  assign any_v = |bus.cm_valid_i;
  assign push  = ready & any_v;
  assign drop  = any_v & ~ready;
  assign valid = (level != '0);
  assign pop   = valid & bus.out_ready_i;
  assign raddr = rd_ptr[AW-1:0];

  // Compaction: each valid lane's slot is the
  // number of valid lanes below it.
  always_comb begin
    cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      off[k]   = cnt[AW-1:0];
      waddr[k] = wr_ptr[AW-1:0] + cnt[AW-1:0];
      cnt      = cnt + PW'(bus.cm_valid_i[k]);
    end
  end

  // Record storage; zero-forced fields keep the
  // trace free of stale rd/store data.
  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int k = 0; k < LANES; k++) begin
        if (bus.cm_valid_i[k]) begin
          pc_q[waddr[k]]  <= bus.cm_pc_i[k*XLEN +: XLEN];
          ins_q[waddr[k]] <= bus.cm_instr_i[k*XLEN +: XLEN];
          rda_q[waddr[k]] <= bus.cm_rd_addr_i[k*5 +: 5];
          rdd_q[waddr[k]] <=
            (bus.cm_rd_addr_i[k*5 +: 5] != 5'd0)
            ? bus.cm_rd_data_i[k*XLEN +: XLEN] : '0;
          mw_q[waddr[k]]  <= bus.cm_mem_wrt_i[k];
          ma_q[waddr[k]]  <= bus.cm_mem_wrt_i[k]
            ? bus.cm_mem_addr_i[k*XLEN +: XLEN] : '0;
          md_q[waddr[k]]  <= bus.cm_mem_wrt_i[k]
            ? bus.cm_mem_data_i[k*XLEN +: XLEN] : '0;
          seq_q[waddr[k]] <= next_seq + SEQ_W'(off[k]);
        end
      end
    end
  end

  // Pointers, occupancy, sequence and drop status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      next_seq <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + cnt;
        next_seq <= next_seq + SEQ_W'(cnt);
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      level <= level + (push ? cnt : '0)
                     - (pop ? PW'(1) : '0);
      if (bus.clear_i) begin
        overflow <= 1'b0;
        drop_cnt <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF)
          drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  assign bus.cm_ready_o  = ready;
  assign bus.out_valid_o = valid;
  assign bus.level_o     = level;
  assign bus.overflow_o  = overflow;
  assign bus.drop_cnt_o  = drop_cnt;

  assign bus.out_seq_o      = valid ? seq_q[raddr] : '0;
  assign bus.out_pc_o       = valid ? pc_q[raddr]  : '0;
  assign bus.out_instr_o    = valid ? ins_q[raddr] : '0;
  assign bus.out_rd_addr_o  = valid ? rda_q[raddr] : '0;
  assign bus.out_rd_data_o  = valid ? rdd_q[raddr] : '0;
  assign bus.out_mem_wrt_o  = valid & mw_q[raddr];
  assign bus.out_mem_addr_o = valid ? ma_q[raddr]  : '0;
  assign bus.out_mem_data_o = valid ? md_q[raddr]  : '0;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer:
// ordering, seq tags, zero-forcing, drops, reset.
module tb_commit_trace_buffer;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  commit_trace_buffer_if bus ();

  commit_trace_buffer dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    bus.cm_valid_i    = '0;
    bus.cm_pc_i       = '0;
    bus.cm_instr_i    = '0;
    bus.cm_rd_addr_i  = '0;
    bus.cm_rd_data_i  = '0;
    bus.cm_mem_wrt_i  = '0;
    bus.cm_mem_addr_i = '0;
    bus.cm_mem_data_i = '0;
  endtask

  task automatic lane(input int k,
                      input logic [31:0] pc,
                      input logic [4:0] rd,
                      input logic [31:0] rdd,
                      input logic mw,
                      input logic [31:0] ma,
                      input logic [31:0] md);
    bus.cm_valid_i[k]          = 1'b1;
    bus.cm_pc_i[k*32 +: 32]    = pc;
    bus.cm_instr_i[k*32 +: 32] = pc ^ 32'h13;
    bus.cm_rd_addr_i[k*5 +: 5] = rd;
    bus.cm_rd_data_i[k*32 +: 32] = rdd;
    bus.cm_mem_wrt_i[k]        = mw;
    bus.cm_mem_addr_i[k*32 +: 32] = ma;
    bus.cm_mem_data_i[k*32 +: 32] = md;
  endtask

  int lvl;
  int exp_seq;
  bit do_push;

  initial begin
    idle();
    bus.out_ready_i = 1'b0;
    bus.clear_i     = 1'b0;
    tick();
    tick();
    rst_i = 1'b0;

    chk("rst_level", bus.level_o, 0);
    chk("rst_valid", bus.out_valid_o, 0);
    chk("rst_ovf", bus.overflow_o, 0);
    chk("rst_drop", bus.drop_cnt_o, 0);
    chk("rst_ready", bus.cm_ready_o, 1);
    chk("rst_pc", bus.out_pc_o, 0);

    // two lanes, drained in order
    bus.out_ready_i = 1'b1;
    lane(0, 32'h100, 5'd1, 32'h11, 0, 0, 0);
    lane(1, 32'h104, 5'd2, 32'h22, 0, 0, 0);
    tick();
    idle();
    chk("t1_lvl0", bus.level_o, 2);
    chk("t1_pc0", bus.out_pc_o, 32'h100);
    chk("t1_seq0", bus.out_seq_o, 0);
    chk("t1_ins0", bus.out_instr_o, 32'h113);
    chk("t1_rdd0", bus.out_rd_data_o, 32'h11);
    tick();
    chk("t1_lvl1", bus.level_o, 1);
    chk("t1_pc1", bus.out_pc_o, 32'h104);
    chk("t1_seq1", bus.out_seq_o, 1);
    tick();
    chk("t1_lvl2", bus.level_o, 0);
    chk("t1_val2", bus.out_valid_o, 0);

    // lane 1 only, rd x0 zero-forced
    lane(1, 32'h200, 5'd0, 32'hDEAD, 0, 0, 0);
    bus.cm_pc_i[31:0] = 32'h999;
    tick();
    idle();
    chk("t2_lvl", bus.level_o, 1);
    chk("t2_pc", bus.out_pc_o, 32'h200);
    chk("t2_seq", bus.out_seq_o, 2);
    chk("t2_rdd", bus.out_rd_data_o, 0);
    tick();
    chk("t2_empty", bus.level_o, 0);

    // store lane and non-store lane
    bus.out_ready_i = 1'b0;
    lane(0, 32'h300, 5'd5, 32'hAA, 1,
         32'h80000010, 32'h12345678);
    lane(1, 32'h304, 5'd6, 32'hBB, 0,
         32'hFFFF, 32'h1234);
    tick();
    idle();
    chk("t4_seq0", bus.out_seq_o, 3);
    chk("t4_mw0", bus.out_mem_wrt_o, 1);
    chk("t4_ma0", bus.out_mem_addr_o, 32'h80000010);
    chk("t4_md0", bus.out_mem_data_o, 32'h12345678);
    chk("t4_rda0", bus.out_rd_addr_o, 5);
    tick();
    chk("t4_hold", bus.out_pc_o, 32'h300);
    bus.out_ready_i = 1'b1;
    tick();
    chk("t4_seq1", bus.out_seq_o, 4);
    chk("t4_mw1", bus.out_mem_wrt_o, 0);
    chk("t4_ma1", bus.out_mem_addr_o, 0);
    chk("t4_md1", bus.out_mem_data_o, 0);
    chk("t4_rdd1", bus.out_rd_data_o, 32'hBB);
    tick();
    chk("t4_empty", bus.level_o, 0);

    // fill to full with no consumer, then drop
    bus.out_ready_i = 1'b0;
    for (int g = 0; g < 4; g++) begin
      chk("t3_rdy", bus.cm_ready_o, 1);
      idle();
      lane(0, 32'h1000 + 8*g, 5'd1, 0, 0, 0, 0);
      lane(1, 32'h1004 + 8*g, 5'd1, 0, 0, 0, 0);
      tick();
    end
    chk("t3_full", bus.level_o, 8);
    chk("t3_nrdy", bus.cm_ready_o, 0);
    lane(0, 32'hBAD0, 5'd1, 0, 0, 0, 0);
    lane(1, 32'hBAD4, 5'd1, 0, 0, 0, 0);
    tick();
    idle();
    chk("t3_lvl", bus.level_o, 8);
    chk("t3_ovf", bus.overflow_o, 1);
    chk("t3_drop", bus.drop_cnt_o, 1);
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    chk("t3_clr_ovf", bus.overflow_o, 0);
    chk("t3_clr_drop", bus.drop_cnt_o, 0);
    bus.out_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t3_dseq", bus.out_seq_o, 5 + i);
      chk("t3_dpc", bus.out_pc_o, 32'h1000 + 4*i);
      tick();
    end
    chk("t3_drained", bus.level_o, 0);
    lane(0, 32'h500, 5'd1, 0, 0, 0, 0);
    tick();
    idle();
    chk("t3_nseq", bus.out_seq_o, 13);
    tick();

    // steady state: push 2 when ready, pop 1
    lvl = 0;
    exp_seq = 14;
    for (int c = 0; c < 20; c++) begin
      chk("t5_lvl", bus.level_o, lvl);
      chk("t5_rdy", bus.cm_ready_o,
          (lvl <= 6) ? 1 : 0);
      if (lvl != 0)
        chk("t5_seq", bus.out_seq_o, exp_seq);
      do_push = (lvl <= 6);
      idle();
      if (do_push) begin
        lane(0, 32'h2000 + 8*c, 5'd3, 0, 0, 0, 0);
        lane(1, 32'h2004 + 8*c, 5'd3, 0, 0, 0, 0);
      end
      tick();
      if (lvl != 0) exp_seq++;
      lvl = lvl + (do_push ? 2 : 0)
                - ((lvl != 0) ? 1 : 0);
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      if (bus.level_o == 0) break;
      chk("t5_dseq", bus.out_seq_o, exp_seq);
      exp_seq++;
      tick();
    end
    chk("t5_empty", bus.level_o, 0);

    // clear beats a simultaneous drop; then reset
    bus.out_ready_i = 1'b0;
    for (int g = 0; g < 4; g++) begin
      lane(0, 32'h3000 + 8*g, 5'd1, 0, 0, 0, 0);
      lane(1, 32'h3004 + 8*g, 5'd1, 0, 0, 0, 0);
      tick();
    end
    chk("t6_full", bus.level_o, 8);
    bus.clear_i = 1'b1;
    tick();
    bus.clear_i = 1'b0;
    chk("t6_cd_ovf", bus.overflow_o, 0);
    chk("t6_cd_drop", bus.drop_cnt_o, 0);
    tick();
    idle();
    chk("t6_ovf", bus.overflow_o, 1);
    chk("t6_drop", bus.drop_cnt_o, 1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("t6_rvalid", bus.out_valid_o, 0);
    chk("t6_rlvl", bus.level_o, 0);
    chk("t6_rovf", bus.overflow_o, 0);
    chk("t6_rdrop", bus.drop_cnt_o, 0);
    bus.out_ready_i = 1'b1;
    lane(1, 32'h600, 5'd1, 0, 0, 0, 0);
    tick();
    idle();
    chk("t6_seq", bus.out_seq_o, 0);
    chk("t6_pc", bus.out_pc_o, 32'h600);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
